// File: rtl/sram_dly_pkg.sv
// Shared types and constants for the SRAM-backed audio delay line.
package sram_dly_pkg;

  localparam int SMP_W      = 16;
  localparam int DEF_ADDR_W = 19;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_LO,
    ST_WR_HI,
    ST_RD_LO,
    ST_RD_HI
  } dly_state_e;

  typedef enum logic [1:0] {
    BM_IDLE,
    BM_ACCESS,
    BM_RELEASE
  } bm_state_e;

endpackage

// File: rtl/sram_delay_line_if.sv
// Byte-wide Wishbone link between the delay line and the external SRAM controller.
interface sram_delay_line_if import sram_dly_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              wb_cyc_o;
  logic              wb_we_o;
  logic [ADDR_W-1:0] wb_adr_o;
  logic [7:0]        wb_dat_o;
  logic              wb_ack_i;
  logic [7:0]        wb_dat_i;

  modport master (
    output wb_cyc_o, wb_we_o, wb_adr_o, wb_dat_o,
    input  wb_ack_i, wb_dat_i
  );

  modport slave (
    input  wb_cyc_o, wb_we_o, wb_adr_o, wb_dat_o,
    output wb_ack_i, wb_dat_i
  );

endinterface

// File: rtl/sram_wb_byte_master.sv
// Single-byte Wishbone access: hold the request until ack, then wait for the
// controller to drop ack before reporting completion.
module sram_wb_byte_master import sram_dly_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start,
  input  logic              we,
  input  logic [ADDR_W-1:0] adr,
  input  logic [7:0]        wdat,
  output logic              done,
  output logic [7:0]        rdat,
  sram_delay_line_if.master wb
);

  bm_state_e         state, state_nx;
  logic              cyc_nx, we_nx;
  logic [ADDR_W-1:0] adr_nx;
  logic [7:0]        dat_nx, rdat_nx;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state       <= BM_IDLE;
      wb.wb_cyc_o <= 1'b0;
      wb.wb_we_o  <= 1'b0;
      wb.wb_adr_o <= '0;
      wb.wb_dat_o <= 8'h00;
      rdat        <= 8'h00;
    end else begin
      state       <= state_nx;
      wb.wb_cyc_o <= cyc_nx;
      wb.wb_we_o  <= we_nx;
      wb.wb_adr_o <= adr_nx;
      wb.wb_dat_o <= dat_nx;
      rdat        <= rdat_nx;
    end
  end

  // Bus outputs only change on entry to and exit from the access phase.
  always_comb begin
    state_nx = state;
    cyc_nx   = wb.wb_cyc_o;
    we_nx    = wb.wb_we_o;
    adr_nx   = wb.wb_adr_o;
    dat_nx   = wb.wb_dat_o;
    rdat_nx  = rdat;
    done     = 1'b0;
    unique case (state)
      BM_IDLE: begin
        if (start) begin
          state_nx = BM_ACCESS;
          cyc_nx   = 1'b1;
          we_nx    = we;
          adr_nx   = adr;
          dat_nx   = we ? wdat : 8'h00;
        end
      end
      BM_ACCESS: begin
        if (wb.wb_ack_i) begin
          state_nx = BM_RELEASE;
          cyc_nx   = 1'b0;
          we_nx    = 1'b0;
          dat_nx   = 8'h00;
          if (!wb.wb_we_o) begin
            rdat_nx = wb.wb_dat_i;
          end
        end
      end
      BM_RELEASE: begin
        if (!wb.wb_ack_i) begin
          state_nx = BM_IDLE;
          done     = 1'b1;
        end
      end
      default: state_nx = BM_IDLE;
    endcase
  end

endmodule

// File: rtl/sram_delay_line.sv
// Audio delay line storing 16-bit samples as byte pairs in an external SRAM:
// each accepted sample is written at wp, then the sample at wp-delay is read back.
module sram_delay_line import sram_dly_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              smp_valid_i,
  input  logic [SMP_W-1:0]  smp_dat_i,
  input  logic [ADDR_W-2:0] delay_i,
  output logic              dly_valid_o,
  output logic [SMP_W-1:0]  dly_dat_o,
  output logic              busy_o,
  output logic              overrun_o,
  sram_delay_line_if.master wb
);

  localparam int PTR_W = ADDR_W - 1;

  dly_state_e        state, state_nx;
  logic [PTR_W-1:0]  wp, dly, rp;
  logic [SMP_W-1:0]  smp;
  logic [7:0]        rd_lo, bm_rdat, bm_wdat;
  logic [ADDR_W-1:0] bm_adr;
  logic              accept, issue, bm_done, bm_we;

  // A stale ack from an access cut short by reset also blocks acceptance.
  assign accept = smp_valid_i && (state == ST_IDLE) && !wb.wb_ack_i;
  assign rp     = wp - dly;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    bm_we    = 1'b0;
    bm_adr   = '0;
    bm_wdat  = 8'h00;
    unique case (state)
      ST_IDLE: begin
        if (accept) state_nx = ST_WR_LO;
      end
      ST_WR_LO: begin
        bm_we   = 1'b1;
        bm_adr  = {wp, 1'b0};
        bm_wdat = smp[7:0];
        if (bm_done) state_nx = ST_WR_HI;
      end
      ST_WR_HI: begin
        bm_we   = 1'b1;
        bm_adr  = {wp, 1'b1};
        bm_wdat = smp[15:8];
        if (bm_done) state_nx = ST_RD_LO;
      end
      ST_RD_LO: begin
        bm_adr = {rp, 1'b0};
        if (bm_done) state_nx = ST_RD_HI;
      end
      ST_RD_HI: begin
        bm_adr = {rp, 1'b1};
        if (bm_done) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // issue fires one cycle after each state entry so the byte master sees the
  // new state's address and data.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wp          <= '0;
      dly         <= '0;
      smp         <= '0;
      rd_lo       <= 8'h00;
      issue       <= 1'b0;
      busy_o      <= 1'b0;
      overrun_o   <= 1'b0;
      dly_valid_o <= 1'b0;
      dly_dat_o   <= '0;
    end else begin
      dly_valid_o <= 1'b0;
      issue       <= accept || (bm_done && state != ST_RD_HI);
      if (smp_valid_i && !accept) begin
        overrun_o <= 1'b1;
      end
      if (accept) begin
        smp    <= smp_dat_i;
        dly    <= delay_i;
        busy_o <= 1'b1;
      end
      if (bm_done && state == ST_RD_LO) begin
        rd_lo <= bm_rdat;
      end
      if (bm_done && state == ST_RD_HI) begin
        dly_dat_o   <= {bm_rdat, rd_lo};
        dly_valid_o <= 1'b1;
        wp          <= wp + 1'b1;
        busy_o      <= 1'b0;
      end
    end
  end

  sram_wb_byte_master #(.ADDR_W(ADDR_W)) u_byte_master (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .start   (issue),
    .we      (bm_we),
    .adr     (bm_adr),
    .wdat    (bm_wdat),
    .done    (bm_done),
    .rdat    (bm_rdat),
    .wb      (wb)
  );

endmodule

// File: tb/tb_sram_delay_line.sv
// Bench for sram_delay_line: byte SRAM controller model, sample-slot reference
// model, bus protocol checker and directed plus randomized scenarios.
module tb_sram_delay_line;
  import sram_dly_pkg::*;

  // A narrow address bus keeps a full pointer wrap within a short run.
  localparam int AW    = 9;
  localparam int DEPTH = 1 << (AW - 1);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [7:0]    dat;
  } acc_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          smp_valid = 1'b0;
  logic [15:0]   smp_dat = 16'h0000;
  logic [AW-2:0] delay = '0;
  logic          dly_valid, busy, overrun;
  logic [15:0]   dly_dat;

  int checks = 0;
  int passes = 0;

  sram_delay_line_if #(.ADDR_W(AW)) bus ();

  sram_delay_line #(.ADDR_W(AW)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .smp_valid_i (smp_valid),
    .smp_dat_i   (smp_dat),
    .delay_i     (delay),
    .dly_valid_o (dly_valid),
    .dly_dat_o   (dly_dat),
    .busy_o      (busy),
    .overrun_o   (overrun),
    .wb          (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] pwr_byte(input int a);
    logic [31:0] v;
    v = a;
    return v[7:0] ^ 8'h5A;
  endfunction

  // SRAM controller model: ack two cycles after cyc, held while cyc is high,
  // cleared two cycles after cyc drops; it has no reset of its own.
  logic       sram_ack = 1'b0;
  logic [7:0] sram_rdat = 8'h00;
  logic [7:0] sram [int];
  acc_t       acc_log [$];
  int         lat_cnt = 0;
  int         gap_cnt = 0;

  assign bus.wb_ack_i = sram_ack;
  assign bus.wb_dat_i = sram_rdat;

  always @(posedge clk) begin
    if (!sram_ack) begin
      gap_cnt <= 0;
      if (bus.wb_cyc_o && lat_cnt == 1) begin
        lat_cnt  <= 0;
        sram_ack <= 1'b1;
        acc_log.push_back({bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o});
        if (bus.wb_we_o) sram[int'(bus.wb_adr_o)] = bus.wb_dat_o;
        else sram_rdat <= sram.exists(int'(bus.wb_adr_o)) ? sram[int'(bus.wb_adr_o)]
                                                           : pwr_byte(int'(bus.wb_adr_o));
      end else begin
        lat_cnt <= bus.wb_cyc_o ? lat_cnt + 1 : 0;
      end
    end else begin
      lat_cnt <= 0;
      if (!bus.wb_cyc_o) begin
        if (gap_cnt == 1) begin
          sram_ack <= 1'b0;
          gap_cnt  <= 0;
        end else begin
          gap_cnt <= gap_cnt + 1;
        end
      end
    end
  end

  // Protocol checker: cyc rises only after a low ack, and the request is stable.
  logic          prev_cyc = 1'b0, prev_we = 1'b0, prev_ack = 1'b0;
  logic [AW-1:0] prev_adr = '0;
  logic [7:0]    prev_dat = 8'h00;
  int            valid_cnt = 0;

  always @(negedge clk) begin
    if (bus.wb_cyc_o && !prev_cyc) checkOutput("cyc_rise_ack_low", {31'd0, prev_ack}, 32'd0);
    if (bus.wb_cyc_o && prev_cyc)
      checkOutput("bus_stable", {bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o}, {prev_we, prev_adr, prev_dat});
    if (bus.wb_cyc_o && !bus.wb_we_o) checkOutput("read_dat_zero", bus.wb_dat_o, 32'd0);
    if (dly_valid) valid_cnt <= valid_cnt + 1;
    prev_cyc <= bus.wb_cyc_o;
    prev_we  <= bus.wb_we_o;
    prev_adr <= bus.wb_adr_o;
    prev_dat <= bus.wb_dat_o;
    prev_ack <= bus.wb_ack_i;
  end

  // Reference model: one 16-bit word per sample slot, written slot = wp.
  logic [15:0] ref_mem [int];
  int          ref_wp = 0;

  function automatic logic [15:0] ref_read(input int slot);
    if (ref_mem.exists(slot)) return ref_mem[slot];
    return {pwr_byte(2 * slot + 1), pwr_byte(2 * slot)};
  endfunction

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    ref_wp = 0;
  endtask

  task automatic expectOutput(input string tag, input int start_cnt, input logic [15:0] exp);
    int n = 0;
    while (valid_cnt == start_cnt && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checkOutput({tag, "_pulses"}, valid_cnt - start_cnt, 32'd1);
    checkOutput({tag, "_dat"}, dly_dat, exp);
    checkOutput({tag, "_busy_clr"}, busy, 32'd0);
  endtask

  task automatic applyStimulus(input logic [15:0] d, input int dl);
    int          start_cnt;
    logic [15:0] exp;
    ref_mem[ref_wp] = d;
    exp       = ref_read((ref_wp - dl + DEPTH) % DEPTH);
    ref_wp    = (ref_wp + 1) % DEPTH;
    start_cnt = valid_cnt;
    @(negedge clk);
    smp_dat   = d;
    delay     = (AW - 1)'(dl);
    smp_valid = 1'b1;
    @(negedge clk);
    smp_valid = 1'b0;
    checkOutput("busy_set", busy, 32'd1);
    expectOutput("sample", start_cnt, exp);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          n;
    int          start_cnt;
    logic        found;
    logic [15:0] d;

    @(negedge clk);
    checkOutput("rst_cyc", bus.wb_cyc_o, 32'd0);
    checkOutput("rst_we", bus.wb_we_o, 32'd0);
    checkOutput("rst_adr", bus.wb_adr_o, 32'd0);
    checkOutput("rst_dat", bus.wb_dat_o, 32'd0);
    checkOutput("rst_dly_valid", dly_valid, 32'd0);
    checkOutput("rst_dly_dat", dly_dat, 32'd0);
    checkOutput("rst_busy", busy, 32'd0);
    checkOutput("rst_overrun", overrun, 32'd0);
    doReset();

    $display("[TB] delay 0 returns the sample just written");
    acc_log.delete();
    applyStimulus(16'h1234, 0);
    checkOutput("d0_acc_count", acc_log.size(), 32'd4);
    checkOutput("d0_wr_lo", acc_log[0], {1'b1, AW'(0), 8'h34});
    checkOutput("d0_wr_hi", acc_log[1], {1'b1, AW'(1), 8'h12});
    checkOutput("d0_rd_lo", acc_log[2], {1'b0, AW'(0), 8'h00});
    checkOutput("d0_rd_hi", acc_log[3], {1'b0, AW'(1), 8'h00});

    $display("[TB] delay 3 over five samples");
    doReset();
    for (int i = 1; i <= 4; i++) applyStimulus(16'(i), 3);
    acc_log.delete();
    applyStimulus(16'h0005, 3);
    checkOutput("d3_out", dly_dat, 32'h0002);
    checkOutput("d3_rd_lo_adr", acc_log[2].adr, 32'd2);
    checkOutput("d3_rd_hi_adr", acc_log[3].adr, 32'd3);

    $display("[TB] randomized samples and delays");
    for (int i = 0; i < 24; i++) begin
      applyStimulus(16'($urandom), (i % 4 == 0) ? int'($urandom_range(0, DEPTH - 1))
                                                : int'($urandom_range(0, 6)));
    end

    $display("[TB] write pointer wrap");
    doReset();
    for (int i = 0; i < DEPTH - 1; i++) applyStimulus(16'($urandom), int'($urandom_range(0, 7)));
    acc_log.delete();
    applyStimulus(16'hBEEF, 0);
    checkOutput("wrap_wr_lo_adr", acc_log[0].adr, 32'(2 * DEPTH - 2));
    checkOutput("wrap_wr_hi_adr", acc_log[1].adr, 32'(2 * DEPTH - 1));
    acc_log.delete();
    applyStimulus(16'h5555, 1);
    checkOutput("wrap_wp0_adr", acc_log[0].adr, 32'd0);
    checkOutput("wrap_rd_adr", acc_log[2].adr, 32'(2 * DEPTH - 2));
    checkOutput("wrap_out", dly_dat, 32'hBEEF);

    $display("[TB] second strobe while busy is dropped");
    doReset();
    checkOutput("ovr_clear", overrun, 32'd0);
    ref_mem[ref_wp] = 16'hA5C3;
    ref_wp    = ref_wp + 1;
    start_cnt = valid_cnt;
    @(negedge clk);
    smp_dat   = 16'hA5C3;
    delay     = '0;
    smp_valid = 1'b1;
    @(negedge clk);
    smp_valid = 1'b0;
    repeat (2) @(negedge clk);
    smp_dat   = 16'h0F0F;
    smp_valid = 1'b1;
    @(negedge clk);
    smp_valid = 1'b0;
    checkOutput("ovr_set", overrun, 32'd1);
    expectOutput("ovr_first", start_cnt, 16'hA5C3);
    applyStimulus(16'h2468, 1);
    checkOutput("ovr_sticky", overrun, 32'd1);
    checkOutput("ovr_second_out", dly_dat, 32'hA5C3);

    $display("[TB] reset during the high-byte write");
    doReset();
    checkOutput("ovr_reset", overrun, 32'd0);
    @(negedge clk);
    smp_dat   = 16'h9ABC;
    delay     = '0;
    smp_valid = 1'b1;
    @(negedge clk);
    smp_valid = 1'b0;
    found = 1'b0;
    n = 0;
    while (!found && n < 100) begin
      found = bus.wb_cyc_o && bus.wb_we_o && bus.wb_adr_o == AW'(1) && bus.wb_ack_i;
      if (!found) begin
        @(negedge clk);
        n++;
      end
    end
    checkOutput("mid_wr_hi_seen", found, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_cyc_drop", bus.wb_cyc_o, 32'd0);
    rst_n     = 1'b1;
    ref_wp    = 0;
    ref_mem[0] = 16'h9ABC;
    smp_dat   = 16'h7777;
    smp_valid = 1'b1;
    @(negedge clk);
    smp_valid = 1'b0;
    checkOutput("stale_ack_reject", overrun, 32'd1);
    checkOutput("stale_ack_not_busy", busy, 32'd0);
    n = 0;
    while (bus.wb_ack_i && n < 20) begin
      @(negedge clk);
      n++;
    end
    acc_log.delete();
    d = 16'h4321;
    applyStimulus(d, 0);
    checkOutput("post_rst_wr_lo", acc_log[0], {1'b1, AW'(0), 8'h21});
    checkOutput("post_rst_wr_hi", acc_log[1], {1'b1, AW'(1), 8'h43});
    checkOutput("post_rst_out", dly_dat, 32'h4321);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
